// File: rtl/spwm_gate_gen_pkg.sv
// Shared types for the SPWM gate generator: carrier direction and the
// per-leg dead-time state machine encoding, plus the sample clamp helper.
package spwm_gate_gen_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        DT_IDLE    = 3'd0,
        DT_LOW_ON  = 3'd1,
        DT_TO_HIGH = 3'd2,
        DT_HIGH_ON = 3'd3,
        DT_TO_LOW  = 3'd4
    } dt_state_e;

    // Saturating clamp of the modulating value to the carrier peak.
    function automatic logic [11:0] clamp_val(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/spwm_deadtime.sv
// One bridge leg: turns a reference level into complementary high/low gate
// drives with a dead band on every transition. Both gates are registered
// decodes of the next state, so they can never be asserted together.
module spwm_deadtime
    import spwm_gate_gen_pkg::*;
#(
    parameter int DEAD_TIME = 20,
    parameter int DT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic leg_ref,
    output logic gate_h,
    output logic gate_l
);

    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEAD_TIME - 1);

    dt_state_e       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            gate_h_q, gate_h_d;
    logic            gate_l_q, gate_l_d;

    // Next-state logic: dead band counts DEAD_TIME cycles; a reference that
    // reverts during the count falls straight back to the side it came from.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = DT_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DT_IDLE: begin
                    state_d = leg_ref ? DT_TO_HIGH : DT_TO_LOW;
                    cnt_d   = '0;
                end
                DT_LOW_ON: begin
                    if (leg_ref) begin
                        state_d = DT_TO_HIGH;
                        cnt_d   = '0;
                    end
                end
                DT_TO_HIGH: begin
                    if (!leg_ref)            state_d = DT_LOW_ON;
                    else if (cnt_q == DT_LAST) state_d = DT_HIGH_ON;
                    else                     cnt_d = cnt_q + DT_W'(1);
                end
                DT_HIGH_ON: begin
                    if (!leg_ref) begin
                        state_d = DT_TO_LOW;
                        cnt_d   = '0;
                    end
                end
                DT_TO_LOW: begin
                    if (leg_ref)             state_d = DT_HIGH_ON;
                    else if (cnt_q == DT_LAST) state_d = DT_LOW_ON;
                    else                     cnt_d = cnt_q + DT_W'(1);
                end
                default: state_d = DT_IDLE;
            endcase
        end
        gate_h_d = (state_d == DT_HIGH_ON);
        gate_l_d = (state_d == DT_LOW_ON);
    end

    // State, dead-band counter and registered gate decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= DT_IDLE;
            cnt_q    <= '0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gate_h_q <= gate_h_d;
            gate_l_q <= gate_l_d;
        end
    end

    assign gate_h = gate_h_q;
    assign gate_l = gate_l_q;

endmodule

// File: rtl/spwm_gate_gen.sv
// Unipolar SPWM gate generator: symmetric triangle carrier, valley-sampled
// modulating value, registered compare, half-cycle leg steering and two
// dead-time legs driving the full bridge.
module spwm_gate_gen
    import spwm_gate_gen_pkg::*;
#(
    parameter int CARRIER_MAX = 4000,
    parameter int DEAD_TIME   = 20,
    parameter int DT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] mod_val,
    input  logic        half_sel,
    output logic        sample_req,
    output logic [11:0] carrier,
    output logic        gate_ah,
    output logic        gate_al,
    output logic        gate_bh,
    output logic        gate_bl
);

    localparam logic [11:0] CMAX = 12'(CARRIER_MAX);

    logic [11:0] carrier_q, carrier_d;
    dir_e        dir_q, dir_d;
    logic        run_q, run_d;
    logic [11:0] held_val_q, held_val_d;
    logic        held_half_q, held_half_d;
    logic        sample_req_q, sample_req_d;
    logic        ref_a_q, ref_a_d;
    logic        ref_b_q, ref_b_d;

    // Carrier stepping, valley sample/hold and the steered compare result.
    // run_q remembers whether the carrier was running last cycle, so the
    // first enabled edge holds the carrier at 0 and counts as a valley.
    always_comb begin
        carrier_d    = carrier_q;
        dir_d        = dir_q;
        run_d        = en;
        held_val_d   = held_val_q;
        held_half_d  = held_half_q;
        sample_req_d = 1'b0;
        ref_a_d      = !held_half_q && (held_val_q > carrier_q);
        ref_b_d      =  held_half_q && (held_val_q > carrier_q);

        if (!en || !run_q) begin
            carrier_d = '0;
            dir_d     = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (carrier_q >= CMAX) begin
                carrier_d = CMAX - 12'd1;
                dir_d     = DIR_DOWN;
            end else begin
                carrier_d = carrier_q + 12'd1;
            end
        end else begin
            if (carrier_q <= 12'd1) begin
                carrier_d = '0;
                dir_d     = DIR_UP;
            end else begin
                carrier_d = carrier_q - 12'd1;
            end
        end

        if (en && (carrier_d == 12'd0)) begin
            sample_req_d = 1'b1;
            held_val_d   = clamp_val(mod_val, CMAX);
            held_half_d  = half_sel;
        end
    end

    // Carrier, hold and compare registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier_q    <= '0;
            dir_q        <= DIR_UP;
            run_q        <= 1'b0;
            held_val_q   <= '0;
            held_half_q  <= 1'b0;
            sample_req_q <= 1'b0;
            ref_a_q      <= 1'b0;
            ref_b_q      <= 1'b0;
        end else begin
            carrier_q    <= carrier_d;
            dir_q        <= dir_d;
            run_q        <= run_d;
            held_val_q   <= held_val_d;
            held_half_q  <= held_half_d;
            sample_req_q <= sample_req_d;
            ref_a_q      <= ref_a_d;
            ref_b_q      <= ref_b_d;
        end
    end

    spwm_deadtime #(.DEAD_TIME(DEAD_TIME), .DT_W(DT_W)) u_leg_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .leg_ref (ref_a_q),
        .gate_h  (gate_ah),
        .gate_l  (gate_al)
    );

    spwm_deadtime #(.DEAD_TIME(DEAD_TIME), .DT_W(DT_W)) u_leg_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .leg_ref (ref_b_q),
        .gate_h  (gate_bh),
        .gate_l  (gate_bl)
    );

    assign sample_req = sample_req_q;
    assign carrier    = carrier_q;

endmodule

// File: tb/tb_spwm_gate_gen.sv
// Self-checking bench for spwm_gate_gen with a cycle-level behavioural model.
module tb_spwm_gate_gen;

    localparam int CM  = 8;
    localparam int DT  = 2;
    localparam int PER = 2 * CM;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] mod_val = '0;
    logic        half_sel = 1'b0;
    logic        sample_req;
    logic [11:0] carrier;
    logic        gate_ah, gate_al, gate_bh, gate_bl;

    int checks = 0;
    int failures = 0;

    spwm_gate_gen #(.CARRIER_MAX(CM), .DEAD_TIME(DT), .DT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mod_val    (mod_val),
        .half_sel   (half_sel),
        .sample_req (sample_req),
        .carrier    (carrier),
        .gate_ah    (gate_ah),
        .gate_al    (gate_al),
        .gate_bh    (gate_bh),
        .gate_bl    (gate_bl)
    );

    always #5 clk = ~clk;

    // Reference model: carrier as a phase within the period (-1 = parked),
    // held sample, registered leg references, and per leg the side it is
    // committed to plus how long it has been waiting to change side.
    int m_phase;
    int m_held;
    bit m_half, m_refa, m_refb, m_sreq;
    bit lg_act[2];
    bit lg_side[2];
    int lg_pend[2];

    function automatic int m_carrier();
        if (m_phase < 0) return 0;
        return (m_phase <= CM) ? m_phase : PER - m_phase;
    endfunction

    task automatic model_reset();
        m_phase = -1; m_held = 0; m_half = 0; m_refa = 0; m_refb = 0; m_sreq = 0;
        for (int i = 0; i < 2; i++) begin
            lg_act[i] = 0; lg_side[i] = 0; lg_pend[i] = 0;
        end
    endtask

    task automatic leg_step(input int i, input bit e, input bit r);
        if (!e) begin
            lg_act[i] = 0; lg_pend[i] = 0;
        end else if (!lg_act[i]) begin
            lg_act[i] = 1; lg_side[i] = !r; lg_pend[i] = 1;
        end else if (lg_pend[i] > 0) begin
            if (r == lg_side[i]) lg_pend[i] = 0;
            else if (lg_pend[i] == DT) begin lg_side[i] = r; lg_pend[i] = 0; end
            else lg_pend[i]++;
        end else if (r != lg_side[i]) begin
            lg_pend[i] = 1;
        end
    endtask

    task automatic model_step(input bit e, input logic [11:0] mv, input bit hs);
        int c_old;
        bit ra, rb;
        c_old = m_carrier();
        ra = m_refa; rb = m_refb;
        m_refa = !m_half && (m_held > c_old);
        m_refb =  m_half && (m_held > c_old);
        leg_step(0, e, ra);
        leg_step(1, e, rb);
        if (!e) m_phase = -1;
        else if (m_phase < 0) m_phase = 0;
        else m_phase = (m_phase + 1) % PER;
        m_sreq = e && (m_phase == 0);
        if (m_sreq) begin
            m_held = (int'(mv) > CM) ? CM : int'(mv);
            m_half = hs;
        end
    endtask

    function automatic logic [16:0] exp_vec();
        logic gah, gal, gbh, gbl;
        gah = lg_act[0] && lg_pend[0] == 0 &&  lg_side[0];
        gal = lg_act[0] && lg_pend[0] == 0 && !lg_side[0];
        gbh = lg_act[1] && lg_pend[1] == 0 &&  lg_side[1];
        gbl = lg_act[1] && lg_pend[1] == 0 && !lg_side[1];
        return {12'(m_carrier()), m_sreq, gah, gal, gbh, gbl};
    endfunction

    logic [16:0] dut_vec;
    assign dut_vec = {carrier, sample_req, gate_ah, gate_al, gate_bh, gate_bl};

    // One clock: advance the model with the inputs the DUT samples, then settle.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(en, mod_val, half_sel);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; mod_val = '0; half_sel = 0;
        model_reset();
        repeat (3) tick();
        checks++;
        if (dut_vec !== 17'd0) begin
            failures++; $display("FAIL reset_hold got=%h want=%h", dut_vec, 17'd0);
        end
        rst_n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (dut_vec !== 17'd0) begin
                failures++; $display("FAIL idle_after_reset cyc=%0d got=%h want=%h", i, dut_vec, 17'd0);
            end
        end
    endtask

    task automatic test_zero();
        int last;
        last = -1;
        mod_val = 12'd0; half_sel = 0; en = 1;
        for (int i = 0; i < 3 * PER; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL zero_model cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            checks++;
            if ((gate_ah | gate_bh) !== 1'b0) begin
                failures++; $display("FAIL zero_high_on cyc=%0d ah=%b bh=%b want 0", i, gate_ah, gate_bh);
            end
            if (i == 0) begin
                checks++;
                if (sample_req !== 1'b1) begin
                    failures++; $display("FAIL zero_first_sample got=%b want=1", sample_req);
                end
            end
            if (i == 1 || i == 2) begin
                checks++;
                if ({gate_al, gate_bl} !== ((i == 2) ? 2'b11 : 2'b00)) begin
                    failures++; $display("FAIL zero_low_delay cyc=%0d got=%b%b", i, gate_al, gate_bl);
                end
            end
            if (sample_req === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != PER) begin
                        failures++; $display("FAIL zero_sample_period got=%0d want=%0d", i - last, PER);
                    end
                end
                last = i;
            end
        end
    endtask

    // A one-cycle low reference interrupts the dead band toward low and the
    // leg falls back to high, so a clamped sample keeps the high side off
    // for a single cycle per period.
    task automatic test_duty(input logic [11:0] mv, input int want_ah, input int want_al);
        int n_ah, n_al, n_bl;
        n_ah = 0; n_al = 0; n_bl = 0;
        mod_val = mv; half_sel = 0; en = 1;
        for (int i = 0; i < 40 + PER; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL duty_model mv=%0d cyc=%0d got=%h want=%h", mv, i, dut_vec, exp_vec());
            end
            checks++;
            if (carrier > 12'(CM)) begin
                failures++; $display("FAIL duty_carrier_range got=%0d want<=%0d", carrier, CM);
            end
            if (i >= 40) begin
                n_ah += int'(gate_ah); n_al += int'(gate_al); n_bl += int'(gate_bl);
            end
        end
        checks++;
        if (n_ah != want_ah || n_al != want_al || n_bl != PER) begin
            failures++;
            $display("FAIL duty_counts mv=%0d got ah=%0d al=%0d bl=%0d want ah=%0d al=%0d bl=%0d",
                     mv, n_ah, n_al, n_bl, want_ah, want_al, PER);
        end
    endtask

    task automatic test_half_toggle();
        int seen, n_bh, n_ah;
        mod_val = 12'd4; half_sel = 0; en = 1;
        seen = 0;
        for (int i = 0; i < 3 * PER && seen == 0; i++) begin
            tick();
            if (sample_req === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin failures++; $display("FAIL half_wait_sample timeout"); end
        repeat (5) tick();
        half_sel = 1;
        seen = 0; n_bh = 0; n_ah = 0;
        for (int i = 0; i < 4 * PER; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL half_model cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            checks++;
            if ((gate_ah & gate_al) | (gate_bh & gate_bl)) begin
                failures++; $display("FAIL half_shoot_through cyc=%0d a=%b%b b=%b%b", i, gate_ah, gate_al, gate_bh, gate_bl);
            end
            if (sample_req === 1'b1) seen = 1;
            if (seen == 0) begin
                checks++;
                if (gate_bh !== 1'b0) begin
                    failures++; $display("FAIL half_early_b cyc=%0d got=%b want=0", i, gate_bh);
                end
            end
            if (i >= 2 * PER) begin
                n_bh += int'(gate_bh); n_ah += int'(gate_ah);
            end
        end
        checks++;
        if (n_bh != 10 || n_ah != 0) begin
            failures++; $display("FAIL half_after_swap got bh=%0d ah=%0d want bh=10 ah=0", n_bh, n_ah);
        end
        half_sel = 0;
    endtask

    task automatic test_en_reset();
        int found;
        mod_val = 12'd4; half_sel = 0; en = 1;
        found = 0;
        for (int i = 0; i < 4 * PER && found == 0; i++) begin
            tick();
            if (gate_ah === 1'b1) found = 1;
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL en_wait_pulse timeout"); end
        en = 0;
        tick();
        checks++;
        if (dut_vec !== 17'd0 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL en_drop got=%h want=%h", dut_vec, 17'd0);
        end
        repeat (3) tick();
        en = 1;
        tick();
        checks++;
        if (sample_req !== 1'b1 || carrier !== 12'd0) begin
            failures++; $display("FAIL en_restart_sample got req=%b car=%0d want req=1 car=0", sample_req, carrier);
        end
        repeat (2 * PER + 5) tick();
        @(posedge clk);
        model_step(en, mod_val, half_sel);
        #3 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 17'd0) begin
            failures++; $display("FAIL async_reset got=%h want=%h", dut_vec, 17'd0);
        end
        repeat (2) tick();
        rst_n = 1;
        tick();
        checks++;
        if (sample_req !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL reset_restart got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        en = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mod_val  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 12)) : 12'($urandom_range(0, 4095));
                half_sel = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, dut_vec, exp_vec());
            end
            checks++;
            if ((gate_ah & gate_al) | (gate_bh & gate_bl)) begin
                failures++; $display("FAIL random_shoot_through cyc=%0d a=%b%b b=%b%b", i, gate_ah, gate_al, gate_bh, gate_bl);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_duty(12'd4, 5, 7);
        test_duty(12'd4000, 15, 0);
        test_half_toggle();
        test_en_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
